// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DATA_W             = 32;
  localparam int unsigned STATE_W            = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 48;

  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_LAUNCH    = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT_DIV  = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT_MULT = 3'd3;
  localparam logic [STATE_W-1:0] S_COMMIT    = 3'd4;

  typedef enum logic {
    OP_DIV  = 1'b0,
    OP_MULT = 1'b1
  } op_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-cycle watchdog; only built when MULDIV_TIMEOUT_EN is defined.
`ifdef MULDIV_TIMEOUT_EN
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
)
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires during the LIMIT-th enabled cycle so WAIT lasts exactly LIMIT cycles.
  assign expired_c = en && (count == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO; launches a unit, waits, commits.
// Optional WAIT watchdog enabled with MULDIV_TIMEOUT_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
`ifdef MULDIV_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_div,
  input  logic        start_mult,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        div_start,
  output logic        mult_start,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        div_done,
  input  logic        div_zero,
  input  logic        mult_done,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        exc_div_zero,
  output logic        req_err,
  output logic        timeout_err
);

  logic [STATE_W-1:0] state, state_d;
  op_e                op, op_d;
  logic [DATA_W-1:0]  unit_a_d, unit_b_d, hi_d, lo_d;
  logic               div_start_d, mult_start_d, done_d, exc_d, req_err_d, timeout_d;
  logic               any_start, wd_expired;

  assign any_start = start_div | start_mult;

`ifdef MULDIV_TIMEOUT_EN
  logic wd_clear, wd_en;

  assign wd_clear = (state == S_LAUNCH);
  assign wd_en    = (state == S_WAIT_DIV) || (state == S_WAIT_MULT);

  muldiv_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear     (wd_clear),
    .en        (wd_en),
    .expired_c (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state;
    op_d         = op;
    unit_a_d     = unit_a;
    unit_b_d     = unit_b;
    hi_d         = hi;
    lo_d         = lo;
    div_start_d  = 1'b0;
    mult_start_d = 1'b0;
    done_d       = 1'b0;
    exc_d        = 1'b0;
    req_err_d    = 1'b0;
    timeout_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (any_start) begin
          unit_a_d     = op_a;
          unit_b_d     = op_b;
          op_d         = start_div ? OP_DIV : OP_MULT;
          div_start_d  = start_div;
          mult_start_d = ~start_div;
          req_err_d    = start_div & start_mult;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        req_err_d = any_start;
        state_d   = (op == OP_DIV) ? S_WAIT_DIV : S_WAIT_MULT;
      end
      S_WAIT_DIV: begin
        req_err_d = any_start;
        // The divider never raises done on a zero divisor, so zero wins.
        if (div_zero) begin
          exc_d   = 1'b1;
          state_d = S_COMMIT;
        end else if (div_done) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_COMMIT;
        end
      end
      S_WAIT_MULT: begin
        req_err_d = any_start;
        if (mult_done) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_COMMIT;
        end
      end
      S_COMMIT: begin
        req_err_d = any_start;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op           <= OP_DIV;
      unit_a       <= '0;
      unit_b       <= '0;
      hi           <= '0;
      lo           <= '0;
      div_start    <= 1'b0;
      mult_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      exc_div_zero <= 1'b0;
      req_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      op           <= op_d;
      unit_a       <= unit_a_d;
      unit_b       <= unit_b_d;
      hi           <= hi_d;
      lo           <= lo_d;
      div_start    <= div_start_d;
      mult_start   <= mult_start_d;
      busy         <= (state_d != S_IDLE);
      done         <= done_d;
      exc_div_zero <= exc_d;
      req_err      <= req_err_d;
      timeout_err  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with stub divide/multiply units.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_div = 1'b0, start_mult = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        div_start, mult_start;
  logic [31:0] unit_a, unit_b, hi, lo;
  logic        div_done = 1'b0, div_zero = 1'b0, mult_done = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
  logic        busy, done, exc_div_zero, req_err, timeout_err;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start_div(start_div), .start_mult(start_mult),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .div_start(div_start), .mult_start(mult_start), .unit_a(unit_a), .unit_b(unit_b),
    .div_done(div_done), .div_zero(div_zero), .mult_done(mult_done),
    .div_hi(div_hi), .div_lo(div_lo), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .exc_div_zero(exc_div_zero),
    .req_err(req_err), .timeout_err(timeout_err)
  );

  int checks = 0, errors = 0;
  int div_lat = 1, mult_lat = 1, div_mode = 0;   // mode 0 done, 1 zero, 2 never
  int dcnt = 0, mcnt = 0;
  int n_div_start = 0, n_mult_start = 0, n_req_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  // Stub units: status levels rise lat+1 cycles after the launch pulse.
  always @(posedge clk) begin
    if (div_start) begin
      dcnt <= div_lat; div_done <= 1'b0; div_zero <= 1'b0;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        if (div_mode == 1) div_zero <= 1'b1;
        else if (div_mode == 0) begin
          div_done <= 1'b1;
          if (unit_b != 0) begin
            div_lo <= unit_a / unit_b;
            div_hi <= unit_a % unit_b;
          end
        end
      end
    end
    if (mult_start) begin
      mcnt <= mult_lat; mult_done <= 1'b0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mult_done <= 1'b1;
        {mult_hi, mult_lo} <= {32'd0, unit_a} * {32'd0, unit_b};
      end
    end
  end

  always @(posedge clk) begin
    if (div_start)  n_div_start  <= n_div_start + 1;
    if (mult_start) n_mult_start <= n_mult_start + 1;
    if (req_err)    n_req_err    <= n_req_err + 1;
  end

  typedef struct {
    bit          is_div;
    logic [31:0] a, b;
    int          lat, mode;
    logic [31:0] ehi, elo;
    int          ek;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_event(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(done || exc_div_zero || timeout_err) && n < 300);
  endtask

  // Launch one op at cycle T and check launch, completion timing, results, idle.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    div_lat = v.lat; mult_lat = v.lat; div_mode = v.mode;
    op_a = v.a; op_b = v.b; start_div = v.is_div; start_mult = !v.is_div;
    tick();
    start_div = 1'b0; start_mult = 1'b0;
    check({tag, " busy@T+1"}, 64'(busy), 64'(1));
    check({tag, " div_start@T+1"}, 64'(div_start), 64'(v.is_div));
    check({tag, " mult_start@T+1"}, 64'(mult_start), 64'(!v.is_div));
    wait_event(n);
    check({tag, " latency"}, 64'(n + 1), 64'(v.ek));
    check({tag, " done"}, 64'(done), 64'(v.mode == 0));
    check({tag, " exc_div_zero"}, 64'(exc_div_zero), 64'(v.mode == 1));
    check({tag, " timeout_err"}, 64'(timeout_err), 64'(v.mode == 2));
    check({tag, " hi"}, 64'(hi), 64'(v.ehi));
    check({tag, " lo"}, 64'(lo), 64'(v.elo));
    check({tag, " unit_a"}, 64'(unit_a), 64'(v.a));
    check({tag, " unit_b"}, 64'(unit_b), 64'(v.b));
    tick();
    check({tag, " busy low"}, 64'(busy), 64'(0));
    check({tag, " pulse width"}, 64'(done | exc_div_zero | timeout_err), 64'(0));
    exp_hi = v.ehi; exp_lo = v.elo;
  endtask

  initial begin
    int n, stray, s_div, s_mult, s_err;
    vec_t v;

    vecs[0] = '{1'b1, 32'd7, 32'd2, 32, 0, 32'd1, 32'd3, 35};
    vecs[1] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 4, 0, 32'd1, 32'd0, 7};
    vecs[2] = '{1'b1, 32'd100, 32'd7, 1, 0, 32'd2, 32'd14, 4};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 32'hFFFF_FFFE, 32'h0000_0001, 6};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 5, 0, 32'd0, 32'hFFFF_FFFF, 8};
    vecs[5] = '{1'b1, 32'd5, 32'd0, 6, 1, 32'h1234, 32'h5678, 9};

    // Reset state
    repeat (3) tick();
    check("rst busy", 64'(busy), 64'(0));
    check("rst hi/lo", {hi, lo}, 64'(0));
    check("rst unit_a/b", {unit_a, unit_b}, 64'(0));
    check("rst pulses", 64'({div_start, mult_start, done, exc_div_zero, req_err, timeout_err}), 64'(0));
    reset = 1'b0;
    tick();

    // Vector 1 leaves div_done high, so the multiply after it sees a stale level.
    for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    hi_we = 1'b1; wdata = 32'h1234; tick(); hi_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    lo_we = 1'b1; wdata = 32'h5678; tick(); lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'h1234, 32'h5678});
    run_op(vecs[5], "divzero");

    // Both starts together, then a start and an mthi while busy.
    div_lat = 3; div_mode = 0;
    s_div = n_div_start; s_mult = n_mult_start; s_err = n_req_err;
    op_a = 32'd20; op_b = 32'd6; start_div = 1'b1; start_mult = 1'b1;
    tick();
    check("dual req_err", 64'(req_err), 64'(1));
    check("dual div_start", 64'({div_start, mult_start}), 64'(2'b10));
    start_div = 1'b0; start_mult = 1'b1; op_a = 32'd99; hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start_mult = 1'b0; hi_we = 1'b0;
    check("busy req_err", 64'(req_err), 64'(1));
    check("busy mthi ignored", 64'(hi), 64'(exp_hi));
    check("busy operand held", 64'(unit_a), 64'(20));
    wait_event(n);
    check("dual latency", 64'(n + 2), 64'(6));
    check("dual result", {hi, lo}, {32'd2, 32'd3});
    tick();
    check("dual req_err count", 64'(n_req_err - s_err), 64'(2));
    check("dual launch counts", {32'(n_div_start - s_div), 32'(n_mult_start - s_mult)}, {32'd1, 32'd0});
    exp_hi = 32'd2; exp_lo = 32'd3;

    // mthi together with an accepted start: applied, then overwritten.
    mult_lat = 2; hi_we = 1'b1; wdata = 32'hAAAA; op_a = 32'd3; op_b = 32'd4; start_mult = 1'b1;
    tick();
    hi_we = 1'b0; start_mult = 1'b0;
    check("mthi with start", 64'(hi), 64'hAAAA);
    wait_event(n);
    check("mthi+mult latency", 64'(n + 1), 64'(5));
    check("mthi+mult result", {hi, lo}, {32'd0, 32'd12});
    tick();
    exp_hi = 32'd0; exp_lo = 32'd12;

    // Reset in WAIT_DIV; the divider's later done must be ignored.
    div_lat = 20; div_mode = 0; op_a = 32'd9; op_b = 32'd2; start_div = 1'b1;
    tick();
    start_div = 1'b0;
    repeat (5) tick();
    check("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid rst busy", 64'(busy), 64'(0));
    check("mid rst hi/lo", {hi, lo}, 64'(0));
    check("mid rst outs", 64'({done, div_start, unit_a}), 64'(0));
    stray = 0;
    repeat (30) begin
      tick();
      if (done || busy) stray++;
    end
    check("stale done after reset", 64'(stray), 64'(0));
    exp_hi = '0; exp_lo = '0;

    // Random ops against arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      v.is_div = ($urandom_range(0, 1) == 1);
      v.a = $urandom;
      v.b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      if (v.b == 0) v.b = 32'd1;
      v.lat = int'($urandom_range(1, 12));
      v.mode = 0;
      if (v.is_div && $urandom_range(0, 5) == 0) begin
        v.b = 32'd0; v.mode = 1; v.ehi = exp_hi; v.elo = exp_lo;
      end else if (v.is_div) begin
        v.ehi = v.a % v.b; v.elo = v.a / v.b;
      end else begin
        {v.ehi, v.elo} = 64'(v.a) * 64'(v.b);
      end
      v.ek = v.lat + 3;
      run_op(v, $sformatf("rnd%0d", i));
    end

`ifdef MULDIV_TIMEOUT_EN
    v = '{1'b1, 32'd8, 32'd3, 2, 2, exp_hi, exp_lo, int'(DEF_TIMEOUT_CYCLES) + 2};
    run_op(v, "timeout");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
